// File: rtl/opram_wr_sched.sv
// opram_wr_sched: clears the operand RAM after reset/flush, then arbitrates its single write port round-robin.
// Define OPRAM_SCHED_PRIO0_EN to give requester 0 fixed top priority over the rotating requesters.
module opram_wr_sched #(
    parameter int NREQ = 3,
    parameter int DEPTH = 32,
    parameter int AW = 5,
    parameter int DW = 2,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            flush_i,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0] req_ready_o,
    output logic            init_done_o,
    output logic            ram_wen_o,
    output logic [AW-1:0]   ram_aw_o,
    output logic [DW-1:0]   ram_di_o
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic {INIT, RUN} state_t;
    state_t state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [PW-1:0] rr_q, rr_d, gnt_idx, idx;
    logic [PW:0] sum;
    logic [NREQ-1:0] cand;
    logic gnt_vld;
    logic wen_q, wen_d, done_q, done_d;
    logic [AW-1:0] aw_q, aw_d;
    logic [DW-1:0] di_q, di_d;
    // Scan downward so the candidate closest to rr_q is the last one written.
    always_comb begin
`ifdef OPRAM_SCHED_PRIO0_EN
        cand = req_valid_i & ~NREQ'(1);
`else
        cand = req_valid_i;
`endif
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + (PW+1)'(k);
            idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
            if (cand[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
`ifdef OPRAM_SCHED_PRIO0_EN
        if (req_valid_i[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = '0;
        end
`endif
        if (state_q != RUN || flush_i) gnt_vld = 1'b0;
        req_ready_o = gnt_vld ? NREQ'(1) << gnt_idx : '0;
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rr_d = rr_q;
        wen_d = 1'b0;
        aw_d = aw_q;
        di_d = di_q;
        done_d = done_q;
        if (state_q == INIT) begin
            if (flush_i) begin
                cnt_d = '0;
            end else begin
                wen_d = 1'b1;
                aw_d = cnt_q[AW-1:0];
                di_d = CLEAR_VAL;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (AW+1)'(DEPTH - 1)) begin
                    state_d = RUN;
                    done_d = 1'b1;
                end
            end
        end else if (flush_i) begin
            state_d = INIT;
            cnt_d = '0;
            done_d = 1'b0;
        end else if (gnt_vld) begin
            wen_d = 1'b1;
            aw_d = req_addr_i[gnt_idx*AW +: AW];
            di_d = req_data_i[gnt_idx*DW +: DW];
            rr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef OPRAM_SCHED_PRIO0_EN
            if (gnt_idx == '0) rr_d = rr_q;
`endif
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            cnt_q <= '0;
            rr_q <= '0;
            wen_q <= 1'b0;
            aw_q <= '0;
            di_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rr_q <= rr_d;
            wen_q <= wen_d;
            aw_q <= aw_d;
            di_q <= di_d;
            done_q <= done_d;
        end
    end
    assign ram_wen_o = wen_q;
    assign ram_aw_o = aw_q;
    assign ram_di_o = di_q;
    assign init_done_o = done_q;
endmodule

// File: tb/tb_opram_wr_sched.sv
// tb_opram_wr_sched: random and directed stimulus against a queue-based write-stream model of the scheduler.
module tb_opram_wr_sched;
    localparam int N = 3, AW = 5, DW = 2, DEPTH = 32;
    logic CLK = 1'b0, RST_N = 1'b1, flush_i = 1'b0;
    logic [N-1:0] req_valid_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0] req_ready_o;
    logic init_done_o, ram_wen_o;
    logic [AW-1:0] ram_aw_o;
    logic [DW-1:0] ram_di_o;
    opram_wr_sched #(.NREQ(N), .DEPTH(DEPTH), .AW(AW), .DW(DW), .CLEAR_VAL(2'b00)) dut (
        .CLK(CLK), .RST_N(RST_N), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .init_done_o(init_done_o),
        .ram_wen_o(ram_wen_o), .ram_aw_o(ram_aw_o), .ram_di_o(ram_di_o)
    );
    always #5 CLK = ~CLK;
    typedef struct { int aw; int di; int cyc; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int n_cmp = 0, n_err = 0, cyc = 0;
    bit in_sweep, exp_done;
    int sweep_pos, rr;
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Each expected write carries the cycle in which it must be on the RAM port.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                chk("write_en", int'(ram_wen_o), 1);
                if (ram_wen_o) begin
                    chk("write_addr", int'(ram_aw_o), mon_e.aw);
                    chk("write_data", int'(ram_di_o), mon_e.di);
                end
            end else begin
                chk("write_en_idle", int'(ram_wen_o), 0);
            end
        end
    end
    function automatic int pick(input logic [N-1:0] v);
        int i;
`ifdef OPRAM_SCHED_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            i = (rr + k) % N;
`ifdef OPRAM_SCHED_PRIO0_EN
            if (i != 0 && v[i]) return i;
`else
            if (v[i]) return i;
`endif
        end
        return -1;
    endfunction
    task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                        input logic f, output logic [N-1:0] rdy);
        int g;
        wr_t w;
        chk("init_done", int'(init_done_o), int'(exp_done));
        req_valid_i = v;
        req_addr_i = a;
        req_data_i = d;
        flush_i = f;
        #1;
        g = (!in_sweep && !f) ? pick(v) : -1;
        chk("req_ready", int'(req_ready_o), g < 0 ? 0 : (1 << g));
        rdy = req_ready_o;
        w.cyc = cyc + 1;
        if (in_sweep) begin
            w.aw = sweep_pos;
            w.di = 0;
            exp_q.push_back(w);
            sweep_pos++;
            if (sweep_pos == DEPTH) begin
                in_sweep = 0;
                exp_done = 1;
            end
        end else if (f) begin
            in_sweep = 1;
            sweep_pos = 0;
            exp_done = 0;
        end else if (g >= 0) begin
            w.aw = int'(a[g*AW +: AW]);
            w.di = int'(d[g*DW +: DW]);
            exp_q.push_back(w);
`ifdef OPRAM_SCHED_PRIO0_EN
            if (g != 0) rr = (g + 1) % N;
`else
            rr = (g + 1) % N;
`endif
        end
        @(negedge CLK);
    endtask
    task automatic do_reset(input int hold);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_wen", int'(ram_wen_o), 0);
        chk("rst_aw", int'(ram_aw_o), 0);
        chk("rst_di", int'(ram_di_o), 0);
        chk("rst_done", int'(init_done_o), 0);
        chk("rst_ready", int'(req_ready_o), 0);
        exp_q.delete();
        in_sweep = 1;
        sweep_pos = 0;
        rr = 0;
        exp_done = 0;
        req_valid_i = '0;
        flush_i = 1'b0;
        repeat (hold) @(negedge CLK);
        RST_N = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
    initial begin
        logic [N-1:0] rdy, pv;
        logic [N*AW-1:0] pa;
        logic [N*DW-1:0] pd;
        logic f;
        #1;
        do_reset(3);
        // Post-reset sweep with requests pending: grants must stay off.
        for (int k = 0; k < DEPTH; k++) step(3'b111, N*AW'($urandom), N*DW'($urandom), 1'b0, rdy);
        for (int k = 0; k < 6; k++) begin
            step(3'b111, N*AW'($urandom), N*DW'($urandom), 1'b0, rdy);
`ifndef OPRAM_SCHED_PRIO0_EN
            chk("rr_order", int'(rdy), 1 << (k % 3));
`endif
        end
        step('0, '0, '0, 1'b0, rdy);
        step(3'b010, 15'(7) << AW, 6'(2'b10) << DW, 1'b0, rdy);
        chk("single_req1", int'(rdy), 2);
        step('0, '0, '0, 1'b0, rdy);
        step('0, '0, '0, 1'b0, rdy);
        step(3'b001, 15'(5), 6'(3), 1'b0, rdy);
        step(3'b001, 15'(9), 6'(1), 1'b1, rdy);
        chk("flush_ready", int'(rdy), 0);
        // Flush dead cycle, then 12 sweep writes before an asynchronous reset.
        for (int k = 0; k < 13; k++) step('0, '0, '0, 1'b0, rdy);
        do_reset(2);
        for (int k = 0; k < DEPTH; k++) step('0, '0, '0, 1'b0, rdy);
`ifdef OPRAM_SCHED_PRIO0_EN
        for (int k = 0; k < 4; k++) begin
            step(3'b101, N*AW'($urandom), N*DW'($urandom), 1'b0, rdy);
            chk("prio0_grant", int'(rdy), 1);
        end
        step(3'b100, N*AW'($urandom), N*DW'($urandom), 1'b0, rdy);
        chk("prio0_release", int'(rdy), 4);
`endif
        pv = '0;
        pa = '0;
        pd = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
                    pd[i*DW +: DW] = DW'($urandom);
                end
            end
            f = !in_sweep && $urandom_range(0, 49) == 0;
            step(pv, pa, pd, f, rdy);
            pv = pv & ~rdy;
        end
        for (int k = 0; k < 3; k++) step('0, '0, '0, 1'b0, rdy);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/opram_wr_sched.md
Name: opram_wr_sched

Overview:
- Write-port scheduler for the 32-entry x 2-bit multi-read operand RAM. That RAM has one write port and no reset.
- After reset, and on flush, the block sweeps every entry to a clear value.
- Outside the sweep, it arbitrates the single write port round-robin among NREQ requesters using a valid/ready handshake.
- Sits between the rename/writeback/commit writers and the RAM's write port (write enable, write address, write data).

Parameters:
- NREQ, 3, number of write requesters (2..8)
- DEPTH, 32, RAM entries; must be 2**AW
- AW, 5, address width
- DW, 2, data width
- CLEAR_VAL, 2'b00, value written to every entry during a sweep

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- flush_i  in  1  pulse: restart the clear sweep
- req_valid_i  in  NREQ  per-requester write request
- req_addr_i  in  NREQ*AW  request address; slice i = requester i
- req_data_i  in  NREQ*DW  request data; slice i = requester i
- req_ready_o  out  NREQ  grant; one-hot or zero
- init_done_o  out  1  high while in RUN (sweep complete)
- ram_wen_o  out  1  RAM write enable (registered)
- ram_aw_o  out  AW  RAM write address (registered)
- ram_di_o  out  DW  RAM write data (registered)

Behaviour:
- Reset (asynchronous, RST_N low):
  - state=INIT, cnt=0, rr_ptr=0.
  - ram_wen_o=0, ram_aw_o=0, ram_di_o=0, init_done_o=0, req_ready_o=0.
- INIT state:
  - req_ready_o=0.
  - Each edge loads the output registers with wen=1, aw=cnt, di=CLEAR_VAL, then cnt++.
  - The edge that loads aw=DEPTH-1 also sets state=RUN and init_done_o=1.
  - First clear write is driven in the first cycle after reset release.
  - A sweep takes exactly DEPTH cycles of ram_wen_o=1 with aw = 0..DEPTH-1 in order.
- RUN state:
  - Grant goes to the first valid requester scanning from rr_ptr upward, wrapping modulo NREQ.
  - req_ready_o[g]=1 combinationally for that requester only.
  - Handshake completes when valid&&ready at an edge.
  - At that edge: output registers load wen=1, aw=req_addr[g], di=req_data[g]; rr_ptr=(g+1) mod NREQ.
  - No valid requester: output registers load wen=0, aw and di hold; rr_ptr holds.
- Latency: accept at edge N; ram_wen_o high during cycle N..N+1; RAM holds the data after edge N+1.
- One write per cycle maximum, so sustained throughput is 1 write/cycle.
- Requester contract: a requester keeps valid, addr and data stable until ready. The block does not buffer.
- Same address from two requesters in consecutive cycles: both writes issue in grant order; the later one wins in the RAM.
- flush_i=1 in RUN:
  - req_ready_o forced 0 that cycle.
  - At the edge: state=INIT, cnt=0, init_done_o=0, output registers load wen=0.
  - Any write already in the output registers (from the previous edge) completes in the flush cycle.
  - Sweep starts with aw=0 in the following cycle.
- flush_i in INIT: cnt restarts at 0 at the edge; the sweep restarts from entry 0.
- Reset asserted mid-sweep or mid-write: immediate return to reset values; the partially written RAM is cleared by the new sweep.
- cnt is AW+1 bits wide; the compare to DEPTH-1 is exact, and cnt never wraps to write entry 0 twice.

Optional Feature:
- Macro: OPRAM_SCHED_PRIO0_EN
- Defined:
  - Requester 0 has fixed highest priority in RUN: whenever req_valid_i[0]=1, it is granted regardless of rr_ptr.
  - rr_ptr is not updated on a requester-0 grant.
  - Requesters 1..NREQ-1 rotate round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters, as above.

Test Plan:
- Reset release, no requests -> ram_wen_o=1 for 32 consecutive cycles with aw 0..31 and di=0; init_done_o=1 in the cycle aw=31; req_ready_o stays 0 throughout.
- RUN, all 3 valid continuously (macro off) -> grants rotate 0,1,2,0,1,2 one per cycle; each grant's addr/data appear on ram_aw_o/ram_di_o in the next cycle.
- RUN, req1 valid addr=7 data=2'b10 alone -> req_ready_o=3'b010 the same cycle; next cycle ram_wen_o=1, ram_aw_o=7, ram_di_o=2'b10; the cycle after, ram_wen_o=0.
- flush_i pulse while req0 valid and a write to addr 5 already registered -> addr-5 write driven in the flush cycle; req_ready_o=0; init_done_o=0 next cycle; sweep restarts at aw=0.
- RST_N asserted mid-sweep at cnt=12 -> outputs zero immediately (asynchronous); after release, the sweep restarts from aw=0 and runs the full 32 cycles.
- OPRAM_SCHED_PRIO0_EN defined, req0 and req2 valid for 4 cycles -> req0 granted all 4 cycles; req2 granted in the first cycle req0 drops.
